// File: rtl/mux_pipe_pkg.sv
// Shared constants and state type for the selecting pipeline stage.
// Holds default WIDTH/NIN and the EMPTY/ONE/FULL occupancy states.
package mux_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NIN   = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_pipe_stage_mux.sv
// mux_nway: combinational N-way word selector.
// Ports: in_data (NIN*WIDTH flattened), sel (SELW), out_data (WIDTH).
// A select of NIN or above yields an all-zero word.
module mux_nway
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NIN   = DEF_NIN,
    parameter int SELW  = $clog2(NIN)
) (
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data
);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NIN; i++) begin
            if (int'(sel) == i) begin
                out_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: valid/ready register slice with a skid entry, fed by an
// N-way selector. Ports: clk, rst_n (async, active-low), in_data/in_sel/
// in_valid/in_ready upstream, out_data/out_valid/out_ready downstream, and
// flush (synchronous kill) only when MUX_PIPE_STAGE_FLUSH_EN is defined.
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NIN   = DEF_NIN,
    parameter int SELW  = $clog2(NIN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef MUX_PIPE_STAGE_FLUSH_EN
    input  logic                 flush,
`endif
    input  logic [NIN*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]      in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    state_t           state_q;
    state_t           state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] sel_word;
    logic             acc;
    logic             dlv;
    logic             kill;
    logic             load_main;
    logic             load_skid;
    logic             move_skid;

    mux_nway #(
        .WIDTH (WIDTH),
        .NIN   (NIN),
        .SELW  (SELW)
    ) u_sel (
        .in_data  (in_data),
        .sel      (in_sel),
        .out_data (sel_word)
    );

`ifdef MUX_PIPE_STAGE_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    // Both flags decode flopped state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    assign acc = in_valid & in_ready;
    assign dlv = out_valid & out_ready;

    always_comb begin
        state_n   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    load_main = 1'b1;
                    state_n   = ONE;
                end
            end
            ONE: begin
                if (acc && dlv) begin
                    load_main = 1'b1;
                end else if (dlv) begin
                    state_n = EMPTY;
                end else if (acc) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end
            end
            FULL: begin
                if (dlv) begin
                    move_skid = 1'b1;
                    state_n   = ONE;
                end
            end
            default: begin
                state_n = EMPTY;
            end
        endcase
        // Kill wins over a same-cycle acceptance; data is don't-care.
        if (kill) begin
            state_n = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_n;
            if (load_main) begin
                main_q <= sel_word;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= sel_word;
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: directed scenarios plus random traffic
// against a queue-based model of the two-entry stage.
module tb_mux_pipe_stage;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N*W-1:0] in_data;
    logic [SW-1:0]  in_sel;
    logic           in_valid;
    logic           out_ready;
    logic           in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           flush;

    logic [3*W-1:0] in3_data;
    logic [1:0]     in3_sel;
    logic           in3_valid;
    logic           out3_ready;
    logic           in3_ready;
    logic           out3_valid;
    logic [W-1:0]   out3_data;

    mux_pipe_stage #(.WIDTH(W), .NIN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_PIPE_STAGE_FLUSH_EN
        .flush     (flush),
`endif
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mux_pipe_stage #(.WIDTH(W), .NIN(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MUX_PIPE_STAGE_FLUSH_EN
        .flush     (1'b0),
`endif
        .in_data   (in3_data),
        .in_sel    (in3_sel),
        .in_valid  (in3_valid),
        .in_ready  (in3_ready),
        .out_data  (out3_data),
        .out_valid (out3_valid),
        .out_ready (out3_ready)
    );

    int checks = 0;
    int errors = 0;
    int ndlv   = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Model: the stage holds up to two words in acceptance order.
    logic [W-1:0] q[$];

    function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                          input int s);
        if (s >= N) return '0;
        return d[s*W +: W];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit dlv;
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            dlv = out_ready && (q.size() > 0);
            if (dlv) begin
                void'(q.pop_front());
                ndlv++;
            end
            if (acc) q.push_back(pick(in_data, int'(in_sel)));
`ifdef MUX_PIPE_STAGE_FLUSH_EN
            if (flush) q.delete();
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() > 0) chk("m_out_data", out_data, q[0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_full(input logic [SW-1:0] s0,
                             input logic [SW-1:0] s1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = s0;
        step();
        in_sel = s1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = '0;
        out_ready  = 1'b1;
        in3_valid  = 1'b0;
        in3_sel    = '0;
        out3_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = 32'h1000_0000 + i;
        for (int i = 0; i < 3; i++) in3_data[i*W +: W] = 32'hA000_0000 + i;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst3_out_valid", {31'd0, out3_valid}, 32'd0);
        rst_n = 1'b1;

        // Streaming, first acceptance on the first edge after reset
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = SW'(k);
            step();
            chk("stream_data", out_data, 32'h1000_0000 + k);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure into FULL, then ordered drain
        fill_full(2'd2, 2'd1);
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_data", out_data, 32'h1000_0002);
        step();
        chk("bp_stable", out_data, 32'h1000_0002);
        out_ready = 1'b1;
        step();
        chk("bp_second", out_data, 32'h1000_0001);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Out-of-range select on the three-channel instance
        in3_valid = 1'b1;
        in3_sel   = 2'd3;
        step();
        chk("oor_valid", {31'd0, out3_valid}, 32'd1);
        chk("oor_data", out3_data, 32'd0);
        in3_sel = 2'd2;
        step();
        chk("in3_ch2", out3_data, 32'hA000_0002);
        in3_valid = 1'b0;

        // Asynchronous reset while FULL
        fill_full(2'd0, 2'd3);
        chk("pre_rst_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_data", out_data, 32'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd3;
        step();
        chk("post_rst_accept", out_data, 32'h1000_0003);
        in_valid = 1'b0;
        step();

`ifdef MUX_PIPE_STAGE_FLUSH_EN
        fill_full(2'd1, 2'd2);
        in_data[0 +: W] = 32'hDEAD_BEEF;
        in_sel   = 2'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("flush_no_deliver", {31'd0, out_valid}, 32'd0);
        end
`endif

        // Random traffic
        ndlv = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_sel    = SW'($urandom_range(0, N - 1));
            for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
`ifdef MUX_PIPE_STAGE_FLUSH_EN
            flush = ($urandom_range(0, 63) == 0);
`endif
            step();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("rand_deliveries", {31'd0, ndlv > 1000}, 32'd1);
        chk("rand_drained", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe_stage.md
MUX_PIPE_STAGE -- requirements
Module: mux_pipe_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: data width of each input and of the output.
REQ-002 The block SHALL have parameter NIN, default 4, legal range 2..16: number of selectable input channels.
REQ-003 The block SHALL have parameter SELW, default $clog2(NIN): width of the select field.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port in_data, input, NIN*WIDTH bits: flattened channels, with channel i at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_sel, input, SELW bits: channel select, sampled with in_data.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the upstream presents a transfer.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a transfer.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the registered selected word.
REQ-011 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream accepts a transfer.
REQ-013 The block SHALL have port flush, input, 1 bit: a synchronous pipeline kill, present only when MUX_PIPE_STAGE_FLUSH_EN is defined.

Function
REQ-014 The block SHALL accept a transfer in every cycle in which in_valid and in_ready are both 1; it SHALL deliver a transfer in every cycle in which out_valid and out_ready are both 1.
REQ-015 When the output register is empty or draining, the block SHALL register the selected word and present it on out_data one cycle after acceptance.
REQ-016 When in_sel is greater than or equal to NIN, the block SHALL capture all-zero data, with no error flag.
REQ-017 The block SHALL contain two storage entries: the main register, which drives out_data, and a skid register.
REQ-018 The block SHALL drive in_ready as the registered inverse of the skid register's valid bit, with no combinational path from out_ready to in_ready.
REQ-019 State EMPTY: on acceptance, the block SHALL load the main register and go to ONE.
REQ-020 State ONE, acceptance and delivery in the same cycle: the block SHALL load the main register and stay in ONE.
REQ-021 State ONE, delivery with no acceptance: the block SHALL go to EMPTY.
REQ-022 State ONE, acceptance with no delivery: the block SHALL load the skid register and go to FULL, with in_ready becoming 0.
REQ-023 State FULL, on delivery: the block SHALL move skid to main and go to ONE, with in_ready becoming 1 in the following cycle.
REQ-024 The block SHALL sustain a throughput of one transfer per cycle while out_ready is held at 1.
REQ-025 The block SHALL deliver data in acceptance order and SHALL never drop or duplicate data, except on flush.
REQ-026 While out_valid is 1 and out_ready is 0, the block SHALL hold out_data stable.

Reset
REQ-027 While rst_n is 0, the block SHALL clear both valid bits, drive out_valid to 0, drive out_data to all zeros, and drive in_ready to 1.
REQ-028 On reset assertion mid-operation, the block SHALL discard all held data immediately.
REQ-029 The first acceptance after reset SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-030 When MUX_PIPE_STAGE_FLUSH_EN is defined, flush=1 SHALL clear both valid bits at the next edge, with in_ready becoming 1 in the following cycle and data contents left don't-care.
REQ-031 When MUX_PIPE_STAGE_FLUSH_EN is defined and flush coincides with acceptance, flush SHALL win and the accepted word SHALL be dropped.
REQ-032 When MUX_PIPE_STAGE_FLUSH_EN is defined and flush coincides with delivery, the delivery SHALL still count downstream.
REQ-033 When MUX_PIPE_STAGE_FLUSH_EN is undefined, the flush port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 Package mux_pipe_pkg SHALL hold the default WIDTH and NIN constants and the state enum type with values EMPTY, ONE and FULL.
REQ-035 The combinational N-way selector SHALL be a sub-module, mux_nway (parameters WIDTH and NIN; out-of-range select yields zero), instantiated once in front of the storage.

Verification
REQ-036 Bench scenario, streaming: WIDTH=32, NIN=4, out_ready=1, channel i=32'h1000_000i, in_sel sequence 0,1,2,3 -> out_data 32'h1000_0000..32'h1000_0003 on consecutive cycles, latency 1, in_ready constantly 1.
REQ-037 Bench scenario, backpressure: out_ready=0, two acceptances with in_sel 2 then 1 -> state FULL and in_ready=0 after the 2nd; raise out_ready -> 32'h1000_0002 then 32'h1000_0001, in order.
REQ-038 Bench scenario, out-of-range select: NIN=3, in_sel=3 -> out_data=0, out_valid=1.
REQ-039 Bench scenario, reset mid-operation: state FULL, rst_n pulsed low between edges -> out_valid=0 and in_ready=1 immediately, out_data=0.
REQ-040 Bench scenario, flush (MUX_PIPE_STAGE_FLUSH_EN defined): state FULL, flush=1 with in_valid=1 -> next cycle out_valid=0 and the incoming word is never delivered.
REQ-041 Bench scenario, random: random in_valid/out_ready at 50% for 10k cycles -> output sequence equals the scoreboard FIFO of accepted selected words.
